// File: rtl/delta_sigma_dac.sv
// delta_sigma_dac: 1-bit delta-sigma DAC channel with selectable first or
// second order noise shaping.
//
// Samples arrive over a valid/ready handshake into a one-entry pending
// buffer. Each sample stays active for OSR modulator ticks. Ticks come from
// an internal clock-enable divider of CLK_DIV clocks.
//
// Ports:
//   Clk, Reset     system clock, synchronous active-high reset
//   Enable         modulator run enable (0 clears divider/counters/integrators)
//   Mode           0 = first order, 1 = second order (latched at boundary)
//   In_Data/Valid  unsigned sample offer; In_Ready = pending buffer empty
//   Out            registered bitstream for the external RC filter
//   Sample_Strobe  one-clock pulse: pending sample became active
//   Underrun       one-clock pulse: boundary reached with nothing pending
module delta_sigma_dac #(
  parameter int WIDTH   = 8,
  parameter int OSR     = 64,
  parameter int CLK_DIV = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Mode,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Out,
  output logic             Sample_Strobe,
  output logic             Underrun
);

  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW  = $clog2(OSR);
  localparam int I1W = WIDTH + 3;
  localparam int I2W = WIDTH + 5;
  // Working width for the second-order sums: wide enough that nothing
  // wraps before saturation is applied.
  localparam int EW  = WIDTH + 7;

  localparam logic signed [EW-1:0] FBV = EW'(1) <<< WIDTH;
  localparam logic signed [EW-1:0] L1  = EW'(1) <<< (WIDTH + 1);
  localparam logic signed [EW-1:0] L2  = EW'(1) <<< (WIDTH + 3);

  logic [DW-1:0]           div_q, div_d;
  logic [OW-1:0]           osr_q, osr_d;
  logic [WIDTH-1:0]        a1_q, a1_d;
  logic signed [I1W-1:0]   i1_q, i1_d;
  logic signed [I2W-1:0]   i2_q, i2_d;
  logic [WIDTH-1:0]        x_q, x_d;
  logic                    mode_q, mode_d;
  logic [WIDTH-1:0]        pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_q, out_d;
  logic                    strobe_q, strobe_d;
  logic                    underrun_q, underrun_d;

  logic                    tick, boundary, accept;
  logic [WIDTH:0]          s1;
  logic signed [EW-1:0]    fb, i1_sum, i1_sat, i2_sum, i2_sat;

  assign tick     = Enable && (div_q == DW'(CLK_DIV - 1));
  assign boundary = tick && (osr_q == OW'(OSR - 1));
  assign accept   = In_Valid && in_ready_q;

  // Modulator datapaths, both evaluated from the current state.
  always_comb begin
    s1     = {1'b0, a1_q} + {1'b0, x_q};
    fb     = out_q ? FBV : '0;
    i1_sum = EW'(i1_q) + EW'(x_q) - fb;
    if (i1_sum > L1)       i1_sat = L1;
    else if (i1_sum < -L1) i1_sat = -L1;
    else                   i1_sat = i1_sum;
    // Second integrator consumes the already-saturated first integrator.
    i2_sum = EW'(i2_q) + i1_sat - fb;
    if (i2_sum > L2)       i2_sat = L2;
    else if (i2_sum < -L2) i2_sat = -L2;
    else                   i2_sat = i2_sum;
  end

  always_comb begin
    div_d       = div_q;
    osr_d       = osr_q;
    a1_d        = a1_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    x_d         = x_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    out_d       = out_q;
    strobe_d    = 1'b0;
    underrun_d  = 1'b0;

    if (!Enable) begin
      div_d = '0;
      osr_d = '0;
      a1_d  = '0;
      i1_d  = '0;
      i2_d  = '0;
      out_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        osr_d = boundary ? '0 : osr_q + 1'b1;
        // The boundary tick still modulates the outgoing sample.
        if (mode_q) begin
          i1_d  = I1W'(i1_sat);
          i2_d  = I2W'(i2_sat);
          out_d = !i2_sat[EW-1] && (i2_sat != '0);
        end else begin
          a1_d  = s1[WIDTH-1:0];
          out_d = s1[WIDTH];
        end
      end
    end

    if (boundary) begin
      if (pend_full_q) begin
        x_d         = pend_q;
        mode_d      = Mode;
        pend_full_d = 1'b0;
        strobe_d    = 1'b1;
        // Integrator state is meaningless across a change of loop order.
        if (Mode != mode_q) begin
          a1_d = '0;
          i1_d = '0;
          i2_d = '0;
        end
      end else begin
        underrun_d = 1'b1;
      end
    end

    // Accept only happens with the buffer empty, so it never collides with
    // the boundary pop; an accept on an empty boundary just fills pending.
    if (accept) begin
      pend_d      = In_Data;
      pend_full_d = 1'b1;
    end

    in_ready_d = !pend_full_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q       <= '0;
      osr_q       <= '0;
      a1_q        <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      x_q         <= '0;
      mode_q      <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= 1'b0;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      osr_q       <= osr_d;
      a1_q        <= a1_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      x_q         <= x_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      in_ready_q  <= in_ready_d;
      out_q       <= out_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign In_Ready      = in_ready_q;
  assign Out           = out_q;
  assign Sample_Strobe = strobe_q;
  assign Underrun      = underrun_q;

endmodule

// File: tb/tb_delta_sigma_dac.sv
// Bench for delta_sigma_dac: two channels (CLK_DIV=1 and CLK_DIV=4, OSR=8,
// WIDTH=8) driven by the same stimulus, each tracked cycle by cycle by an
// integer reference model, plus directed density/timing checks.
module tb_delta_sigma_dac;

  localparam int W   = 8;
  localparam int OSR = 8;
  localparam int FS  = 1 << W;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Enable = 1'b0;
  logic         Mode = 1'b0;
  logic [W-1:0] In_Data = '0;
  logic         In_Valid = 1'b0;
  logic         rdy0, out0, str0, und0;
  logic         rdy1, out1, str1, und1;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  delta_sigma_dac #(.WIDTH(W), .OSR(OSR), .CLK_DIV(1)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(rdy0),
    .Out(out0), .Sample_Strobe(str0), .Underrun(und0)
  );

  delta_sigma_dac #(.WIDTH(W), .OSR(OSR), .CLK_DIV(4)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(rdy1),
    .Out(out1), .Sample_Strobe(str1), .Underrun(und1)
  );

  // Reference model state, one slot per channel.
  int m_div[2], m_osr[2], m_a1[2], m_i1[2], m_i2[2], m_x[2], m_pend[2];
  bit m_mode[2], m_full[2], m_out[2], m_str[2], m_und[2];

  function automatic int sat(input int v, input int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_step(input int k, input int cdiv);
    bit tick, bnd, acc;
    int fb, s;
    if (Reset) begin
      m_div[k] = 0; m_osr[k] = 0; m_a1[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
      m_x[k] = 0; m_pend[k] = 0; m_mode[k] = 0; m_full[k] = 0;
      m_out[k] = 0; m_str[k] = 0; m_und[k] = 0;
      return;
    end
    acc  = In_Valid && !m_full[k];
    tick = Enable && (m_div[k] == cdiv - 1);
    bnd  = tick && (m_osr[k] == OSR - 1);
    m_str[k] = 0;
    m_und[k] = 0;
    if (!Enable) begin
      m_div[k] = 0; m_osr[k] = 0; m_a1[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
      m_out[k] = 0;
    end else begin
      m_div[k] = tick ? 0 : m_div[k] + 1;
      if (tick) begin
        m_osr[k] = bnd ? 0 : m_osr[k] + 1;
        fb = m_out[k] ? FS : 0;
        if (m_mode[k]) begin
          m_i1[k]  = sat(m_i1[k] + m_x[k] - fb, 2 * FS);
          m_i2[k]  = sat(m_i2[k] + m_i1[k] - fb, 8 * FS);
          m_out[k] = (m_i2[k] > 0);
        end else begin
          s        = m_a1[k] + m_x[k];
          m_out[k] = (s >= FS);
          m_a1[k]  = s % FS;
        end
      end
    end
    if (bnd) begin
      if (m_full[k]) begin
        if (Mode != m_mode[k]) begin
          m_a1[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
        end
        m_x[k] = m_pend[k]; m_mode[k] = Mode; m_full[k] = 0; m_str[k] = 1;
      end else begin
        m_und[k] = 1;
      end
    end
    if (acc) begin
      m_pend[k] = int'(In_Data);
      m_full[k] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic clk1();
    @(posedge Clk);
    model_step(0, 1);
    model_step(1, 4);
    @(negedge Clk);
    chk("out0", out0, m_out[0]);
    chk("rdy0", rdy0, !m_full[0]);
    chk("str0", str0, m_str[0]);
    chk("und0", und0, m_und[0]);
    chk("out1", out1, m_out[1]);
    chk("rdy1", rdy1, !m_full[1]);
    chk("str1", str1, m_str[1]);
    chk("und1", und1, m_und[1]);
  endtask

  task automatic offer(input int d);
    In_Data  = W'(d);
    In_Valid = 1'b1;
    clk1();
    In_Valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, output int n);
    bit got;
    got = 0;
    n = 0;
    while (!got && n < 64) begin
      clk1();
      n++;
      got = str0;
    end
    chk(tag, got, 1'b1);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      clk1();
      ones += int'(out0);
    end
  endtask

  // 0,0,0,1 repeating for x=64 from a cleared first-order accumulator.
  task automatic chk_pattern(input string tag);
    for (int i = 0; i < 8; i++) begin
      clk1();
      chk(tag, out0, logic'((i % 4) == 3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ones, unds;
    bit pre, done;

    // Reset state
    clk1(); clk1();
    chk("rst_out", out0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_strobe", str0, 1'b0);
    chk("rst_underrun", und0, 1'b0);
    Reset = 1'b0;
    clk1();

    // First order, x=64: strobe one clock after the 8th tick
    Enable = 1'b1;
    Mode   = 1'b0;
    In_Data = W'(64);
    In_Valid = 1'b1;
    clk1();
    In_Valid = 1'b0;
    n = 1;
    if (!str0) begin
      wait_strobe("strobe_x64", ones);
      n += ones;
    end
    chk_int("strobe_latency", n, 8);
    chk_pattern("pattern_x64");
    count_ones(256, ones);
    chk_int("ones_x64", ones, 64);

    offer(255);
    wait_strobe("strobe_x255", n);
    count_ones(256, ones);
    chk_int("ones_x255", ones, 255);

    offer(0);
    wait_strobe("strobe_x0", n);
    count_ones(256, ones);
    chk_int("ones_x0", ones, 0);

    // Second order
    Mode = 1'b1;
    offer(128);
    wait_strobe("strobe_m1_128", n);
    count_ones(1024, ones);
    chk("density_m1_128", logic'(ones >= 510 && ones <= 514), 1'b1);

    offer(255);
    wait_strobe("strobe_m1_255", n);
    count_ones(1024, ones);
    chk("density_m1_255", logic'(ones >= 1016), 1'b1);

    // Enable drop with a sample left pending
    Enable = 1'b0;
    offer(100);
    chk("dis_out_zero", out0, 1'b0);
    for (int i = 0; i < 9; i++) clk1();
    chk("dis_pending_kept", rdy0, 1'b0);
    Enable = 1'b1;
    wait_strobe("strobe_reenable", n);
    chk_int("reenable_latency", n, 8);

    // Back-to-back samples: second waits with In_Ready low until the boundary
    offer(200);
    In_Data  = W'(50);
    In_Valid = 1'b1;
    done = 0;
    for (int i = 0; i < 32 && !done; i++) begin
      pre = rdy0;
      clk1();
      if (pre) done = 1;
      else if (rdy0) chk("ready_rise_on_strobe", str0, 1'b1);
    end
    In_Valid = 1'b0;
    chk("second_accepted", logic'(done), 1'b1);
    wait_strobe("strobe_second", n);
    unds = 0;
    for (int i = 0; i < 8; i++) begin
      clk1();
      unds += int'(und0);
    end
    chk_int("underrun_once", unds, 1);

    // Mode change mid-period takes effect (and clears integrators) at boundary
    offer(64);
    clk1(); clk1();
    Mode = 1'b0;
    wait_strobe("strobe_mode_change", n);
    chk_pattern("pattern_after_mode_change");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      In_Valid = logic'($urandom_range(0, 1));
      In_Data  = W'($urandom);
      if ($urandom_range(0, 63) == 0) Mode = ~Mode;
      Enable = logic'($urandom_range(0, 99) > 3);
      Reset  = logic'($urandom_range(0, 499) == 0);
      clk1();
    end
    Reset = 1'b0;
    In_Valid = 1'b0;
    Enable = 1'b1;
    clk1();

    // Reset mid-period with pending full
    In_Data  = W'(77);
    In_Valid = 1'b1;
    for (int i = 0; i < 32 && rdy0; i++) clk1();
    In_Valid = 1'b0;
    chk("pending_full_before_reset", rdy0, 1'b0);
    clk1(); clk1();
    Reset = 1'b1;
    clk1();
    chk("mid_rst_out", out0, 1'b0);
    chk("mid_rst_ready", rdy0, 1'b1);
    chk("mid_rst_strobe", str0, 1'b0);
    chk("mid_rst_underrun", und0, 1'b0);
    chk("mid_rst_ready1", rdy1, 1'b1);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) clk1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
